// File: rtl/vga_480p_pkg.sv
// ---------------------------------------------------------------------------
// vga_480p_pkg
// Shared constants and types for the 640x480p60 pixel-domain blocks.
//   H_RES / V_RES   : active area size
//   LINE / SCREEN   : last sx / sy value of the full timing raster
//   colr_t          : 12-bit RGB, 4 bits per channel, {R,G,B}
//   PALETTE         : square colours used when colour cycling is compiled in;
//                     entry 0 is the default square colour
// ---------------------------------------------------------------------------
package vga_480p_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int LINE   = 799;
    localparam int SCREEN = 524;

    typedef logic [11:0] colr_t;

    // Packed so that PALETTE[i] selects entry i (entry 0 is the rightmost).
    localparam logic [7:0][11:0] PALETTE = {
        12'hF80, 12'h8F0, 12'hFFF, 12'hF0F,
        12'h0CF, 12'h3F3, 12'hF30, 12'hFC0
    };

endpackage

// File: rtl/bounce_axis.sv
// ---------------------------------------------------------------------------
// bounce_axis
// Position and direction of the square along one screen axis. The position
// moves by SPEED on every unpaused frame strobe and reverses at either edge
// of the active area, clamping exactly onto the edge.
// Ports:
//   i_clk, i_rst : pixel clock, asynchronous active-high reset
//   i_strobe     : one-cycle frame update strobe
//   i_pause      : freezes the axis when high during the strobe
//   o_pos        : current top/left coordinate of the square, 0..RES-SIZE
//   o_flip       : high in the strobe cycle in which the direction reverses
// ---------------------------------------------------------------------------
module bounce_axis #(
    parameter int RES   = 640,
    parameter int SIZE  = 32,
    parameter int SPEED = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_strobe,
    input  logic       i_pause,
    output logic [9:0] o_pos,
    output logic       o_flip
);
    // Limits held at 11 bits so that subtracting SPEED never underflows.
    localparam logic [10:0] P_MAX = 11'(RES - SIZE);
    localparam logic [10:0] P_HI  = 11'(RES - SIZE - SPEED);
    localparam logic [10:0] P_SPD = 11'(SPEED);

    logic [9:0]  r_pos;
    logic        r_dir_pos;   // 1 = moving towards higher coordinates
    logic [10:0] w_pos;
    logic        w_step;
    logic        w_hit;

    assign w_pos  = {1'b0, r_pos};
    assign w_step = i_strobe & ~i_pause;
    // The next step would reach or pass the edge in the current direction.
    assign w_hit  = r_dir_pos ? (w_pos >= P_HI) : (w_pos <= P_SPD);
    assign o_flip = w_step & w_hit;
    assign o_pos  = r_pos;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pos     <= '0;
            r_dir_pos <= 1'b1;
        end else if (w_step) begin
            if (r_dir_pos) begin
                if (w_hit) begin
                    r_pos     <= P_MAX[9:0];
                    r_dir_pos <= 1'b0;
                end else begin
                    r_pos <= 10'(w_pos + P_SPD);
                end
            end else begin
                if (w_hit) begin
                    r_pos     <= '0;
                    r_dir_pos <= 1'b1;
                end else begin
                    r_pos <= 10'(w_pos - P_SPD);
                end
            end
        end
    end

endmodule

// File: rtl/bounce_square_480p.sv
// ---------------------------------------------------------------------------
// bounce_square_480p
// Pixel stage after the 640x480p60 timing generator: draws a solid square on
// a background colour and moves it once per frame, bouncing off the edges.
// Every output field has a latency of exactly 2 pixel clocks from the inputs.
// Build option: define BOUNCE_COLOUR_CYCLE_EN to step the square colour
// through PALETTE on every bounce; otherwise the square is always SQ_COLR.
// Ports:
//   clk_pix, rst_pix            : pixel clock, asynchronous active-high reset
//   sx, sy                      : screen position from the timing generator
//   hsync_in, vsync_in, de_in   : generator syncs (active low) and data enable
//   pause                       : freezes the animation, sampled at the strobe
//   vga_r, vga_g, vga_b         : registered 4:4:4 colour, 0 in blanking
//   vga_hsync, vga_vsync, vga_de: syncs and de delayed to match the colour
//   frame_cnt                   : number of completed frame updates, wraps
// ---------------------------------------------------------------------------
module bounce_square_480p #(
    parameter int          H_RES   = vga_480p_pkg::H_RES,
    parameter int          V_RES   = vga_480p_pkg::V_RES,
    parameter int          SQ_SIZE = 32,
    parameter int          SPEED   = 1,
    parameter logic [11:0] BG_COLR = 12'h137,
    parameter logic [11:0] SQ_COLR = 12'hFC0
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
    input  logic [9:0]  sx,
    input  logic [9:0]  sy,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic        pause,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic [15:0] frame_cnt
);
    import vga_480p_pkg::*;

    logic        w_strobe;
    logic [9:0]  w_qx;
    logic [9:0]  w_qy;
    logic        w_flip_x;
    logic        w_flip_y;
    logic        w_in_sq;
    colr_t       w_sq_colr;

    logic        r_in_sq_s1;
    logic        r_de_s1;
    logic        r_hs_s1;
    logic        r_vs_s1;
    colr_t       r_colr;
    logic        r_hs_s2;
    logic        r_vs_s2;
    logic        r_de_s2;
    logic [15:0] r_frame_cnt;

    // First pixel of the first blanking line: once per frame, never while
    // the square can be on screen, so position changes cannot tear.
    assign w_strobe = (sx == 10'd0) && (sy == 10'(V_RES));

    bounce_axis #(.RES(H_RES), .SIZE(SQ_SIZE), .SPEED(SPEED)) u_axis_x (
        .i_clk    (clk_pix),
        .i_rst    (rst_pix),
        .i_strobe (w_strobe),
        .i_pause  (pause),
        .o_pos    (w_qx),
        .o_flip   (w_flip_x)
    );

    bounce_axis #(.RES(V_RES), .SIZE(SQ_SIZE), .SPEED(SPEED)) u_axis_y (
        .i_clk    (clk_pix),
        .i_rst    (rst_pix),
        .i_strobe (w_strobe),
        .i_pause  (pause),
        .o_pos    (w_qy),
        .o_flip   (w_flip_y)
    );

    // 11-bit compare so qx+SQ_SIZE cannot wrap at the right/bottom edge.
    assign w_in_sq = ({1'b0, sx} >= {1'b0, w_qx}) &&
                     ({1'b0, sx} <  ({1'b0, w_qx} + 11'(SQ_SIZE))) &&
                     ({1'b0, sy} >= {1'b0, w_qy}) &&
                     ({1'b0, sy} <  ({1'b0, w_qy} + 11'(SQ_SIZE)));

`ifdef BOUNCE_COLOUR_CYCLE_EN
    logic [2:0] r_colr_idx;

    // A corner hit flips both axes but counts as a single bounce.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_colr_idx <= '0;
        end else if (w_flip_x | w_flip_y) begin
            r_colr_idx <= r_colr_idx + 3'd1;
        end
    end

    assign w_sq_colr = (r_colr_idx == 3'd0) ? SQ_COLR : PALETTE[r_colr_idx];
`else
    logic w_unused_flip;
    assign w_unused_flip = w_flip_x | w_flip_y;
    assign w_sq_colr     = SQ_COLR;
`endif

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_frame_cnt <= '0;
        end else if (w_strobe && !pause) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Two-stage pixel pipeline: stage 1 decides coverage, stage 2 colour.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_in_sq_s1 <= 1'b0;
            r_de_s1    <= 1'b0;
            r_hs_s1    <= 1'b1;
            r_vs_s1    <= 1'b1;
            r_colr     <= '0;
            r_hs_s2    <= 1'b1;
            r_vs_s2    <= 1'b1;
            r_de_s2    <= 1'b0;
        end else begin
            r_in_sq_s1 <= w_in_sq;
            r_de_s1    <= de_in;
            r_hs_s1    <= hsync_in;
            r_vs_s1    <= vsync_in;
            r_colr     <= r_de_s1 ? (r_in_sq_s1 ? w_sq_colr : BG_COLR) : '0;
            r_hs_s2    <= r_hs_s1;
            r_vs_s2    <= r_vs_s1;
            r_de_s2    <= r_de_s1;
        end
    end

    assign vga_r     = r_colr[11:8];
    assign vga_g     = r_colr[7:4];
    assign vga_b     = r_colr[3:0];
    assign vga_hsync = r_hs_s2;
    assign vga_vsync = r_vs_s2;
    assign vga_de    = r_de_s2;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_bounce_square_480p.sv
// ---------------------------------------------------------------------------
// tb_bounce_square_480p
// Drives screen positions directly (no full raster) so that many frame
// updates fit in a short run. Expected outputs come from a closed-form model:
// with a speed of one pixel, the square position after n moves is a
// triangle wave of period 2*(RES-SIZE), and a bounce happens on every move
// that is a multiple of RES-SIZE on either axis.
// ---------------------------------------------------------------------------
module tb_bounce_square_480p;

  localparam int          HR  = 640;
  localparam int          VR  = 480;
  localparam int          SQ  = 32;
  localparam logic [11:0] BG  = 12'h137;
  localparam logic [11:0] SQC = 12'hFC0;

  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic [9:0]  sx, sy;
  logic        hsync_in, vsync_in, de_in, pause;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_de;
  logic [15:0] frame_cnt;

  always #5 clk_pix = ~clk_pix;

  bounce_square_480p dut (
    .clk_pix   (clk_pix),
    .rst_pix   (rst_pix),
    .sx        (sx),
    .sy        (sy),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .de_in     (de_in),
    .pause     (pause),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .vga_hsync (vga_hsync),
    .vga_vsync (vga_vsync),
    .vga_de    (vga_de),
    .frame_cnt (frame_cnt)
  );

  typedef struct packed {
    logic [31:0] due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] fc;
    logic        chk_fc;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] pal [8];
  int          cyc    = 0;
  int          n_vec  = 0;
  int          n_err  = 0;
  int          moves  = 0;   // unpaused frame updates since reset
  int          fc_m   = 0;
  int          cidx   = 0;

  always @(posedge clk_pix) cyc <= cyc + 1;

  function automatic int tri_pos(input int n, input int lim);
    int m;
    m = n % (2 * lim);
    return (m <= lim) ? m : (2 * lim - m);
  endfunction

  function automatic logic [11:0] sq_col(input int idx);
`ifdef BOUNCE_COLOUR_CYCLE_EN
    return pal[idx];
`else
    return (idx >= 0) ? SQC : SQC;
`endif
  endfunction

  // ---- driver: one pixel per call, expected result queued for 2 cycles on
  task automatic drive(input int x, input int y, input logic hs,
                       input logic vs, input logic pse);
    int          qx, qy;
    logic        de, in_sq;
    exp_t        e, prev;
    @(posedge clk_pix);
    #1;
    sx       = 10'(x);
    sy       = 10'(y);
    hsync_in = hs;
    vsync_in = vs;
    pause    = pse;
    de       = (x < HR) && (y < VR);
    de_in    = de;
    qx       = tri_pos(moves, HR - SQ);
    qy       = tri_pos(moves, VR - SQ);
    in_sq    = (x >= qx) && (x < qx + SQ) && (y >= qy) && (y < qy + SQ);
    e.due    = 32'(cyc + 2);
    e.rgb    = !de ? 12'h000 : (in_sq ? sq_col(cidx) : BG);
    e.hs     = hs;
    e.vs     = vs;
    e.de     = de;
    if (x == 0 && y == VR) begin
      // the previous pixel's output is sampled after this update lands
      if (exp_q.size() > 0) begin
        prev = exp_q.pop_back();
        prev.chk_fc = 1'b0;
        exp_q.push_back(prev);
      end
      if (!pse) begin
        moves = moves + 1;
        fc_m  = (fc_m + 1) % 65536;
        if ((moves % (HR - SQ)) == 0 || (moves % (VR - SQ)) == 0)
          cidx = (cidx + 1) % 8;
      end
    end
    e.fc     = 16'(fc_m);
    e.chk_fc = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic advance(input logic p);
    drive(799, 479, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
    drive(0, VR, 1'b1, 1'b1, p);
    drive(1, VR, 1'b1, 1'b1, ~p);
    drive(2, VR, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] expv);
    n_vec = n_vec + 1;
    if (act !== expv) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk_pix);
    @(negedge clk_pix);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
  endtask

  // ---- monitor / scoreboard
  always @(negedge clk_pix) begin
    exp_t e;
    if (!rst_pix && exp_q.size() > 0) begin
      if (exp_q[0].due <= 32'(cyc)) begin
        e = exp_q.pop_front();
        n_vec = n_vec + 1;
        if (e.due != 32'(cyc) ||
            {vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_de} !==
            {e.rgb, e.hs, e.vs, e.de}) begin
          n_err = n_err + 1;
          $display("FAIL pixel cyc=%0d due=%0d: got rgb=%h hs=%b vs=%b de=%b want rgb=%h hs=%b vs=%b de=%b",
                   cyc, e.due, {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync,
                   vga_de, e.rgb, e.hs, e.vs, e.de);
        end
        if (e.chk_fc) begin
          n_vec = n_vec + 1;
          if (frame_cnt !== e.fc) begin
            n_err = n_err + 1;
            $display("FAIL frame_cnt cyc=%0d: got %0d want %0d",
                     cyc, frame_cnt, e.fc);
          end
        end
      end
    end
  end

  // ---- stimulus
  initial begin
    int  qx, qy;
    logic p;
    pal = '{12'hFC0, 12'hF30, 12'h3F3, 12'h0CF,
            12'hF0F, 12'hFFF, 12'h8F0, 12'hF80};
    rst_pix  = 1'b1;
    sx       = '0;
    sy       = '0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    de_in    = 1'b0;
    pause    = 1'b0;
    repeat (3) @(posedge clk_pix);
    #2;
    chk("reset_rgb", 16'({vga_r, vga_g, vga_b}), 16'h000);
    chk("reset_syncs", 16'({vga_hsync, vga_vsync}), 16'h3);
    chk("reset_de", 16'(vga_de), 16'h0);
    chk("reset_frame_cnt", frame_cnt, 16'h0);
    @(negedge clk_pix);
    rst_pix = 1'b0;

    // first frame: square at the origin
    drive(0, 0, 1'b1, 1'b1, 1'b0);
    drive(32, 0, 1'b1, 1'b1, 1'b0);
    drive(700, 0, 1'b1, 1'b1, 1'b0);
    drive(31, 31, 1'b1, 1'b1, 1'b0);
    drive(0, 32, 1'b1, 1'b1, 1'b0);

    // one full line with the generator's hsync pulse
    for (int x = 0; x < 800; x++)
      drive(x, 10, !(x >= 656 && x <= 751), 1'b1, 1'b0);
    // vsync pulse lines, sampled a few pixels each
    for (int y = 488; y <= 493; y++)
      for (int x = 0; x < 4; x++)
        drive(700 + x, y, 1'b1, !(y == 490 || y == 491), 1'b0);

    // frame updates with edge probes around the modelled square
    for (int f = 1; f <= 1000; f++) begin
      p = (f >= 300 && f <= 302) || (f > 700 && $urandom_range(0, 7) == 0);
      advance(p);
      qx = tri_pos(moves, HR - SQ);
      qy = tri_pos(moves, VR - SQ);
      drive(qx, qy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      drive(qx + SQ - 1, qy + SQ - 1, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
      if (qx + SQ < HR) drive(qx + SQ, qy, 1'b1, 1'b1, 1'b0);
      else              drive(qx - 1, qy, 1'b1, 1'b1, 1'b0);
      if (qy > 0) drive(qx, qy - 1, 1'b1, 1'b1, 1'b0);
      else        drive(qx, qy + SQ, 1'b1, 1'b1, 1'b0);
      drive($urandom_range(0, 799), $urandom_range(0, 479),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    drain();

    // asynchronous reset in the middle of a line
    drive(300, 200, 1'b1, 1'b1, 1'b0);
    drive(301, 200, 1'b0, 1'b0, 1'b0);
    @(posedge clk_pix);
    #3;
    rst_pix = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rgb", 16'({vga_r, vga_g, vga_b}), 16'h000);
    chk("async_syncs", 16'({vga_hsync, vga_vsync}), 16'h3);
    chk("async_de", 16'(vga_de), 16'h0);
    chk("async_frame_cnt", frame_cnt, 16'h0);
    moves = 0;
    fc_m  = 0;
    cidx  = 0;
    @(negedge clk_pix);
    rst_pix = 1'b0;
    drive(0, 0, 1'b1, 1'b1, 1'b0);
    drive(31, 31, 1'b1, 1'b1, 1'b0);
    drive(32, 0, 1'b1, 1'b1, 1'b0);
    drive(300, 200, 1'b1, 1'b1, 1'b0);
    advance(1'b0);
    drive(0, 0, 1'b1, 1'b1, 1'b0);
    drive(1, 1, 1'b1, 1'b1, 1'b0);
    drive(33, 1, 1'b1, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
